// File: rtl/uart_tx_fifo_if.sv
// Byte-write handshake and serial-side status bundle for the FIFO-buffered UART transmitter.
`timescale 1ns/1ps
interface uart_tx_fifo_if #(
  parameter int unsigned FIFO_AW = 2
);
  logic             i_Tx_DV;
  logic [7:0]       i_Tx_Byte;
  logic             o_Tx_Ready;
  logic             o_Tx_Serial;
  logic             o_Tx_Active;
  logic             o_Tx_Done;
  logic             o_Overflow;
  logic [FIFO_AW:0] o_Fifo_Count;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Overflow, o_Fifo_Count
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Overflow, o_Fifo_Count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular FIFO; serialises queued bytes LSB first.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic          i_Clock,
  input  logic          i_Rst_n,
  uart_tx_fifo_if.slave tx
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               ready_q, overflow_q;
  logic               wr_en, pop;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               serial_q, serial_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
  logic               bit_end;

  // Ready comes from the registered count, so a full FIFO never writes through on a pop
  assign wr_en   = tx.i_Tx_DV & ready_q;
  assign bit_end = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q    <= count_d;
      ready_q    <= (count_d != CW'(DEPTH));
      overflow_q <= tx.i_Tx_DV & ~ready_q;
    end
  end

  // Storage needs no reset: pointers and count define which entries are valid
  always_ff @(posedge i_Clock) begin
    if (wr_en) mem[wr_ptr_q] <= tx.i_Tx_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  // serial_d is the line level for the state being entered, keeping the pin registered
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = 1'b1;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = mem[rd_ptr_q];
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = START;
          serial_d  = 1'b0;
        end
      end
      START: begin
        serial_d = 1'b0;
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = DATA;
          serial_d  = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        serial_d = shift_q[bit_idx_q];
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = shift_q[bit_idx_q + 3'd1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = CLEANUP;
          done_d    = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      CLEANUP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    active_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
  end

  assign tx.o_Tx_Ready   = ready_q;
  assign tx.o_Tx_Serial  = serial_q;
  assign tx.o_Tx_Active  = active_q;
  assign tx.o_Tx_Done    = done_q;
  assign tx.o_Overflow   = overflow_q;
  assign tx.o_Fifo_Count = count_q;
endmodule
